// File: rtl/mac_accumulate.sv
// rtl/mac_accumulate.sv - Q8.8 multiply-accumulate with bias, last/overrun close and held result
// Accumulator wraps modulo 2^INTERNAL_BITS; Acc_out is Q16.16 for the downstream truncate stage.
module mac_accumulate #(
  parameter int MAX_TAPS      = 9,
  parameter int DATA_BITS     = 16,
  parameter int INTERNAL_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     In_valid,
  output logic                     In_ready,
  input  logic [DATA_BITS-1:0]     Data_in,
  input  logic [DATA_BITS-1:0]     Weight_in,
  input  logic [DATA_BITS-1:0]     Bias_in,
  input  logic                     Last_in,
  output logic [INTERNAL_BITS-1:0] Acc_out,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic                     Out_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [8:0] MAX_TAPS_W = 9'(MAX_TAPS);

  state_t                            state;
  logic signed [INTERNAL_BITS-1:0]   acc;
  logic [7:0]                        cnt;
  logic                              in_ready_q;
  logic                              out_valid_q;
  logic                              out_overrun_q;

  logic signed [2*DATA_BITS-1:0]     prod;
  logic signed [INTERNAL_BITS-1:0]   prod_ext;
  logic signed [INTERNAL_BITS-1:0]   bias_q16;
  logic signed [INTERNAL_BITS-1:0]   acc_sum;
  logic [8:0]                        cnt_after;
  logic                              take;
  logic                              closing;

  always_comb begin
    prod      = $signed(Data_in) * $signed(Weight_in);
    prod_ext  = INTERNAL_BITS'(prod);
    bias_q16  = INTERNAL_BITS'($signed(Bias_in)) <<< 8;
    take      = In_valid && in_ready_q;
    // The first tap of an operation seeds the sum with the bias instead of the old accumulator.
    acc_sum   = ((state == S_IDLE) ? bias_q16 : acc) + prod_ext;
    cnt_after = (state == S_IDLE) ? 9'd1 : ({1'b0, cnt} + 9'd1);
    closing   = Last_in || (cnt_after == MAX_TAPS_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      acc           <= '0;
      cnt           <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_overrun_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACC: begin
          in_ready_q <= 1'b1;
          if (take) begin
            acc <= acc_sum;
            cnt <= cnt_after[7:0];
            if (closing) begin
              state         <= S_DONE;
              in_ready_q    <= 1'b0;
              out_valid_q   <= 1'b1;
              out_overrun_q <= !Last_in;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_DONE: begin
          // Result stays frozen until the consumer takes it; a one-cycle bubble follows.
          if (Out_ready) begin
            state         <= S_IDLE;
            cnt           <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_overrun_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign In_ready    = in_ready_q;
  assign Acc_out     = acc;
  assign Out_valid   = out_valid_q;
  assign Out_overrun = out_overrun_q;

endmodule

// File: tb/tb_mac_accumulate.sv
// tb/tb_mac_accumulate.sv - self-checking bench for mac_accumulate against a dot-product model
`timescale 1ns/1ps
module tb_mac_accumulate;

  logic        clk;
  logic        rst_n;
  logic        In_valid, In_ready;
  logic [15:0] Data_in, Weight_in, Bias_in;
  logic        Last_in;
  logic [31:0] Acc_out;
  logic        Out_valid, Out_ready, Out_overrun;

  logic        v1, r1, ov1, ovr1, ord1;
  logic [31:0] acc1;

  int n_pass  = 0;
  int n_total = 0;
  bit tmo;

  mac_accumulate #(.MAX_TAPS(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .In_valid(In_valid), .In_ready(In_ready),
    .Data_in(Data_in), .Weight_in(Weight_in), .Bias_in(Bias_in), .Last_in(Last_in),
    .Acc_out(Acc_out), .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_overrun(Out_overrun)
  );

  mac_accumulate #(.MAX_TAPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .In_valid(v1), .In_ready(r1),
    .Data_in(Data_in), .Weight_in(Weight_in), .Bias_in(Bias_in), .Last_in(Last_in),
    .Acc_out(acc1), .Out_valid(ov1), .Out_ready(ord1), .Out_overrun(ovr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic send_tap(input logic [15:0] d, input logic [15:0] w,
                          input logic [15:0] b, input logic last);
    int k = 0;
    while (!In_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!In_ready) tmo = 1'b1;
    Data_in = d; Weight_in = w; Bias_in = b; Last_in = last;
    In_valid = 1'b1;
    @(posedge clk); #1;
    In_valid = 1'b0;
  endtask

  task automatic release_result();
    Out_ready = 1'b1;
    @(posedge clk); #1;
    Out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (In_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", In_ready); else n_pass++;
    n_total++; if (Out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", Out_valid); else n_pass++;
    n_total++; if (Acc_out !== 32'h0) $display("FAIL reset_acc_out: got %h want 0", Acc_out); else n_pass++;
    n_total++; if (Out_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", Out_overrun); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_total++; if (In_ready !== 1'b0) $display("FAIL reset_ready_before_edge: got %b want 0", In_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (In_ready !== 1'b1) $display("FAIL reset_ready_after_edge: got %b want 1", In_ready); else n_pass++;
    n_total++; if (r1 !== 1'b1) $display("FAIL reset_ready_max1: got %b want 1", r1); else n_pass++;
  endtask

  task automatic test_basic();
    tmo = 1'b0;
    send_tap(16'h0100, 16'h0200, 16'h0080, 1'b0);
    n_total++; if (Out_valid !== 1'b0) $display("FAIL basic_valid_mid: got %b want 0", Out_valid); else n_pass++;
    send_tap(16'h0100, 16'h0200, 16'h7fff, 1'b0);
    send_tap(16'h0100, 16'h0200, 16'h7fff, 1'b1);
    n_total++; if (tmo !== 1'b0) $display("FAIL basic_timeout: got %b want 0", tmo); else n_pass++;
    n_total++; if (Out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", Out_valid); else n_pass++;
    n_total++; if (Acc_out !== 32'h0006_8000) $display("FAIL basic_acc: got %h want 00068000", Acc_out); else n_pass++;
    n_total++; if (Out_overrun !== 1'b0) $display("FAIL basic_overrun: got %b want 0", Out_overrun); else n_pass++;
    n_total++; if (In_ready !== 1'b0) $display("FAIL basic_ready_done: got %b want 0", In_ready); else n_pass++;
    release_result();
    n_total++; if (Out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", Out_valid); else n_pass++;
    n_total++; if (In_ready !== 1'b1) $display("FAIL basic_ready_rise: got %b want 1", In_ready); else n_pass++;
  endtask

  task automatic test_negative();
    tmo = 1'b0;
    send_tap(16'hFF00, 16'h0300, 16'h0000, 1'b1);
    n_total++; if (Out_valid !== 1'b1) $display("FAIL neg_valid: got %b want 1", Out_valid); else n_pass++;
    n_total++; if (Acc_out !== 32'hFFFD_0000) $display("FAIL neg_acc: got %h want fffd0000", Acc_out); else n_pass++;
    n_total++; if (tmo !== 1'b0) $display("FAIL neg_timeout: got %b want 0", tmo); else n_pass++;
    release_result();
  endtask

  task automatic test_overrun();
    tmo = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_total++; if (Out_valid !== 1'b0) $display("FAIL ovr_valid_early tap %0d: got %b want 0", i, Out_valid); else n_pass++;
      send_tap(16'h0100, 16'h0100, 16'h0000, 1'b0);
    end
    n_total++; if (tmo !== 1'b0) $display("FAIL ovr_timeout: got %b want 0", tmo); else n_pass++;
    n_total++; if (Out_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", Out_valid); else n_pass++;
    n_total++; if (Acc_out !== 32'h0009_0000) $display("FAIL ovr_acc: got %h want 00090000", Acc_out); else n_pass++;
    n_total++; if (Out_overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", Out_overrun); else n_pass++;
    n_total++; if (In_ready !== 1'b0) $display("FAIL ovr_tenth_ready: got %b want 0", In_ready); else n_pass++;
  endtask

  task automatic test_hold();
    Data_in = 16'h7fff; Weight_in = 16'h7fff; Last_in = 1'b0; In_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_total++; if (Acc_out !== 32'h0009_0000) $display("FAIL hold_acc cyc %0d: got %h want 00090000", c, Acc_out); else n_pass++;
      n_total++; if (Out_valid !== 1'b1 || Out_overrun !== 1'b1) $display("FAIL hold_flags cyc %0d: got %b%b want 11", c, Out_valid, Out_overrun); else n_pass++;
      n_total++; if (In_ready !== 1'b0) $display("FAIL hold_ready cyc %0d: got %b want 0", c, In_ready); else n_pass++;
    end
    Out_ready = 1'b1;
    @(posedge clk); #1;
    Out_ready = 1'b0; In_valid = 1'b0;
    n_total++; if (Out_valid !== 1'b0 || Out_overrun !== 1'b0) $display("FAIL hold_release: got %b%b want 00", Out_valid, Out_overrun); else n_pass++;
    n_total++; if (In_ready !== 1'b1) $display("FAIL hold_ready_rise: got %b want 1", In_ready); else n_pass++;
    tmo = 1'b0;
    send_tap(16'h0100, 16'h0100, 16'h0000, 1'b1);
    n_total++; if (Acc_out !== 32'h0001_0000 || Out_overrun !== 1'b0) $display("FAIL hold_next_op: got %h/%b want 00010000/0", Acc_out, Out_overrun); else n_pass++;
    release_result();
  endtask

  task automatic test_reset_mid();
    tmo = 1'b0;
    send_tap(16'h0100, 16'h0200, 16'h0080, 1'b0);
    send_tap(16'h0100, 16'h0200, 16'h0080, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    n_total++; if (Acc_out !== 32'h0) $display("FAIL rstmid_acc: got %h want 0", Acc_out); else n_pass++;
    n_total++; if (In_ready !== 1'b0 || Out_valid !== 1'b0 || Out_overrun !== 1'b0) $display("FAIL rstmid_flags: got %b%b%b want 000", In_ready, Out_valid, Out_overrun); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    send_tap(16'h0100, 16'h0100, 16'h0000, 1'b1);
    n_total++; if (tmo !== 1'b0) $display("FAIL rstmid_timeout: got %b want 0", tmo); else n_pass++;
    n_total++; if (Acc_out !== 32'h0001_0000 || Out_valid !== 1'b1) $display("FAIL rstmid_fresh: got %h/%b want 00010000/1", Acc_out, Out_valid); else n_pass++;
    release_result();
  endtask

  task automatic test_max1();
    n_total++; if (r1 !== 1'b1) $display("FAIL max1_ready: got %b want 1", r1); else n_pass++;
    Data_in = 16'h0100; Weight_in = 16'h0400; Bias_in = 16'h0100; Last_in = 1'b0; v1 = 1'b1;
    @(posedge clk); #1 v1 = 1'b0;
    n_total++; if (ov1 !== 1'b1 || ovr1 !== 1'b1) $display("FAIL max1_overrun: got %b%b want 11", ov1, ovr1); else n_pass++;
    n_total++; if (acc1 !== 32'h0005_0000) $display("FAIL max1_acc: got %h want 00050000", acc1); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (ov1 !== 1'b0 || r1 !== 1'b1) $display("FAIL max1_release: got %b%b want 01", ov1, r1); else n_pass++;
    Last_in = 1'b1; Bias_in = 16'h0000; v1 = 1'b1;
    @(posedge clk); #1 v1 = 1'b0;
    n_total++; if (ov1 !== 1'b1 || ovr1 !== 1'b0 || acc1 !== 32'h0004_0000) $display("FAIL max1_last: got %b%b %h want 10 00040000", ov1, ovr1, acc1); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic signed [15:0] ds, ws, bs;
    longint exp_sum;
    logic [31:0] exp32;
    bit exp_ovr;
    int n, ntaken;
    for (int op = 0; op < 25; op++) begin
      tmo = 1'b0;
      n = $urandom_range(1, 12);
      bs = 16'($urandom);
      exp_sum = longint'(bs) * 256;
      ntaken = 0;
      exp_ovr = 1'b0;
      for (int i = 0; i < n && ntaken < 9; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        ds = 16'($urandom);
        ws = 16'($urandom);
        send_tap(ds, ws, (i == 0) ? bs : 16'($urandom), (i == n - 1));
        exp_sum += longint'(ds) * longint'(ws);
        ntaken++;
        exp_ovr = (ntaken == 9) && (i != n - 1);
      end
      exp32 = exp_sum[31:0];
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      n_total++; if (tmo !== 1'b0) $display("FAIL rand_timeout op %0d: got %b want 0", op, tmo); else n_pass++;
      n_total++; if (Out_valid !== 1'b1) $display("FAIL rand_valid op %0d: got %b want 1", op, Out_valid); else n_pass++;
      n_total++; if (Acc_out !== exp32) $display("FAIL rand_acc op %0d: got %h want %h", op, Acc_out, exp32); else n_pass++;
      n_total++; if (Out_overrun !== exp_ovr) $display("FAIL rand_overrun op %0d: got %b want %b", op, Out_overrun, exp_ovr); else n_pass++;
      release_result();
      n_total++; if (Out_valid !== 1'b0) $display("FAIL rand_release op %0d: got %b want 0", op, Out_valid); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b0; Last_in = 1'b0;
    Data_in = '0; Weight_in = '0; Bias_in = '0;
    v1 = 1'b0; ord1 = 1'b1; tmo = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_overrun();
    test_hold();
    test_reset_mid();
    test_max1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
